// File: rtl/izh_neuron_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : izh_neuron_scheduler
// Description : Time-multiplexes one shared Izhikevich update datapath over
//               NUM_NEURONS virtual neurons. Per-neuron v/u (2.16 signed),
//               type code and input current are held in local register
//               arrays. Each tick starts a sweep in index order: operands
//               are issued, the datapath result is written back DP_LAT
//               cycles later, and per-neuron spikes are collected into
//               spike_vec at the end of the sweep.
// Ports       : clk, rst_n            clock, asynchronous active-low reset
//               ena, tick             enable and timestep strobe
//               cfg_we/cfg_idx/cfg_type, cur_we/cur_val
//                                     type-code / input-current writes
//                                     (both target cfg_idx)
//               dp_valid, dp_idx, dp_v, dp_u, dp_i, dp_type
//                                     operand issue to the datapath
//               dp_v_new, dp_u_new, dp_spike
//                                     datapath results
//               busy, sweep_done, spike_vec, overrun
//                                     sweep status
//               mon_idx, v_mon, spike_cnt
//                                     monitor port
// Options     : define IZH_SPIKE_CNT_EN to add per-neuron saturating 8-bit
//               spike counters read through spike_cnt (else tied to 0).
// Revision    : 1.0 - initial release
// ============================================================================
module izh_neuron_scheduler #(
    parameter int NUM_NEURONS = 4,
    parameter int IDX_W       = 2,
    parameter int DW          = 18,
    parameter int DP_LAT      = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic                   tick,
    input  logic                   cfg_we,
    input  logic [IDX_W-1:0]       cfg_idx,
    input  logic [3:0]             cfg_type,
    input  logic                   cur_we,
    input  logic [7:0]             cur_val,
    output logic                   dp_valid,
    output logic [IDX_W-1:0]       dp_idx,
    output logic [DW-1:0]          dp_v,
    output logic [DW-1:0]          dp_u,
    output logic [7:0]             dp_i,
    output logic [3:0]             dp_type,
    input  logic [DW-1:0]          dp_v_new,
    input  logic [DW-1:0]          dp_u_new,
    input  logic                   dp_spike,
    output logic                   busy,
    output logic                   sweep_done,
    output logic [NUM_NEURONS-1:0] spike_vec,
    output logic                   overrun,
    input  logic [IDX_W-1:0]       mon_idx,
    output logic [7:0]             v_mon,
    output logic [7:0]             spike_cnt
);

    localparam int               CNT_W     = $clog2(DP_LAT + 1);
    localparam logic [DW-1:0]    C_V_RST   = 18'h3_4CCD;   // -0.7
    localparam logic [DW-1:0]    C_U_RST   = 18'h3_CCCD;   // -0.2
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(NUM_NEURONS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    logic [IDX_W-1:0]       r_idx;
    logic [CNT_W-1:0]       r_cnt;
    logic [NUM_NEURONS-1:0] r_work;

    logic [DW-1:0]          r_v    [NUM_NEURONS];
    logic [DW-1:0]          r_u    [NUM_NEURONS];
    logic [3:0]             r_type [NUM_NEURONS];
    logic [7:0]             r_cur  [NUM_NEURONS];

    logic                   w_wb;
    logic [IDX_W-1:0]       w_issue_idx;
    logic [3:0]             w_issue_type;
    logic [7:0]             w_issue_cur;

    // Write-back happens on the last WAIT cycle, when the datapath result
    // for r_idx is valid on dp_*_new.
    assign w_wb = (r_state == S_WAIT) && (r_cnt == CNT_W'(1));

    // Operands are registered on the edge that enters ISSUE, so a cfg/cur
    // write landing on that same edge is forwarded. This gives the same
    // result as reading the array during the ISSUE cycle itself: writes in
    // the cycle before ISSUE are seen, writes during ISSUE are not.
    always_comb begin
        w_issue_idx  = (r_state == S_IDLE) ? '0 : r_idx + IDX_W'(1);
        w_issue_type = r_type[w_issue_idx];
        w_issue_cur  = r_cur[w_issue_idx];
        if (cfg_we && (cfg_idx == w_issue_idx)) begin
            w_issue_type = cfg_type;
        end
        if (cur_we && (cfg_idx == w_issue_idx)) begin
            w_issue_cur = cur_val;
        end
    end

    // Sweep FSM with registered outputs and v/u state arrays.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_work     <= '0;
            dp_valid   <= 1'b0;
            dp_idx     <= '0;
            dp_v       <= '0;
            dp_u       <= '0;
            dp_i       <= '0;
            dp_type    <= '0;
            busy       <= 1'b0;
            sweep_done <= 1'b0;
            spike_vec  <= '0;
            overrun    <= 1'b0;
            for (int k = 0; k < NUM_NEURONS; k++) begin
                r_v[k] <= C_V_RST;
                r_u[k] <= C_U_RST;
            end
        end else begin
            // Sticky: any tick that arrives while a sweep is running.
            if (tick && (r_state != S_IDLE)) begin
                overrun <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    dp_valid   <= 1'b0;
                    sweep_done <= 1'b0;
                    if (tick && ena) begin
                        r_state  <= S_ISSUE;
                        r_idx    <= w_issue_idx;
                        r_work   <= '0;
                        busy     <= 1'b1;
                        dp_valid <= 1'b1;
                        dp_idx   <= w_issue_idx;
                        dp_v     <= r_v[w_issue_idx];
                        dp_u     <= r_u[w_issue_idx];
                        dp_i     <= w_issue_cur;
                        dp_type  <= w_issue_type;
                    end
                end

                S_ISSUE: begin
                    dp_valid <= 1'b0;
                    r_cnt    <= CNT_W'(DP_LAT);
                    r_state  <= S_WAIT;
                end

                S_WAIT: begin
                    if (w_wb) begin
                        r_v[r_idx]    <= dp_v_new;
                        r_u[r_idx]    <= dp_u_new;
                        r_work[r_idx] <= dp_spike;
                        if (r_idx == C_IDX_LAST) begin
                            r_state    <= S_DONE;
                            sweep_done <= 1'b1;
                        end else begin
                            r_state  <= S_ISSUE;
                            r_idx    <= w_issue_idx;
                            dp_valid <= 1'b1;
                            dp_idx   <= w_issue_idx;
                            dp_v     <= r_v[w_issue_idx];
                            dp_u     <= r_u[w_issue_idx];
                            dp_i     <= w_issue_cur;
                            dp_type  <= w_issue_type;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                S_DONE: begin
                    sweep_done <= 1'b0;
                    spike_vec  <= r_work;
                    busy       <= 1'b0;
                    r_state    <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Configuration arrays: writable in any state; cfg_type above 6 is
    // stored unchanged and interpreted downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_NEURONS; k++) begin
                r_type[k] <= '0;
                r_cur[k]  <= '0;
            end
        end else begin
            if (cfg_we) begin
                r_type[cfg_idx] <= cfg_type;
            end
            if (cur_we) begin
                r_cur[cfg_idx] <= cur_val;
            end
        end
    end

    assign v_mon = r_v[mon_idx][DW-1:DW-8];

`ifdef IZH_SPIKE_CNT_EN
    logic [7:0] r_spk_cnt [NUM_NEURONS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_NEURONS; k++) begin
                r_spk_cnt[k] <= '0;
            end
        end else if (w_wb && dp_spike && (r_spk_cnt[r_idx] != 8'hFF)) begin
            r_spk_cnt[r_idx] <= r_spk_cnt[r_idx] + 8'd1;
        end
    end

    assign spike_cnt = r_spk_cnt[mon_idx];
`else
    assign spike_cnt = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_izh_neuron_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_izh_neuron_scheduler
// Description : Self-checking bench for izh_neuron_scheduler. A one-cycle
//               datapath model returns v+1/u+1 and a spike per spike_mask.
//               Expected operand issues are queued when a sweep is started
//               and compared as dp_valid appears; sweep-level results come
//               from a table and hand-written corner-case sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_izh_neuron_scheduler;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b0;
    logic        tick = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_idx = '0;
    logic [3:0]  cfg_type = '0;
    logic        cur_we = 1'b0;
    logic [7:0]  cur_val = '0;
    logic        dp_valid;
    logic [1:0]  dp_idx;
    logic [17:0] dp_v, dp_u;
    logic [7:0]  dp_i;
    logic [3:0]  dp_type;
    logic [17:0] dp_v_new = '0;
    logic [17:0] dp_u_new = '0;
    logic        dp_spike = 1'b0;
    logic        busy, sweep_done, overrun;
    logic [3:0]  spike_vec;
    logic [1:0]  mon_idx = '0;
    logic [7:0]  v_mon, spike_cnt;

    izh_neuron_scheduler dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .tick(tick),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_type(cfg_type),
        .cur_we(cur_we), .cur_val(cur_val),
        .dp_valid(dp_valid), .dp_idx(dp_idx), .dp_v(dp_v), .dp_u(dp_u),
        .dp_i(dp_i), .dp_type(dp_type),
        .dp_v_new(dp_v_new), .dp_u_new(dp_u_new), .dp_spike(dp_spike),
        .busy(busy), .sweep_done(sweep_done), .spike_vec(spike_vec),
        .overrun(overrun), .mon_idx(mon_idx), .v_mon(v_mon),
        .spike_cnt(spike_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int t0  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath model, latency 1.
    logic [3:0] spike_mask = '0;
    always @(posedge clk) begin
        dp_v_new <= dp_v + 18'd1;
        dp_u_new <= dp_u + 18'd1;
        dp_spike <= dp_valid & spike_mask[dp_idx];
    end

    // Bench model of neuron state.
    logic [17:0] mv [N];
    logic [17:0] mu [N];
    logic [7:0]  mi [N];
    logic [3:0]  mt [N];
    int          cm [N];

    typedef struct {
        int          idx;
        logic [17:0] v;
        logic [17:0] u;
        logic [7:0]  i;
        logic [3:0]  t;
        int          rel;
    } issue_t;
    issue_t sb[$];

    typedef struct { logic [1:0] mon; logic [7:0] exp_v; } mon_vec_t;
    typedef struct { logic [3:0] mask; logic [3:0] exp_sv; } sweep_vec_t;
    mon_vec_t   mon_tbl [4];
    sweep_vec_t sw_tbl  [4];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            mv[k] = 18'h3_4CCD;
            mu[k] = 18'h3_CCCD;
            mi[k] = '0;
            mt[k] = '0;
            cm[k] = 0;
        end
    endtask

    function automatic logic [7:0] exp_spike_cnt(input int k);
`ifdef IZH_SPIKE_CNT_EN
        return 8'(cm[k]);
`else
        return 8'h00;
`endif
    endfunction

    // Scoreboard consumer: every issue must match the next queued entry.
    always @(negedge clk) begin
        if (rst_n && dp_valid) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_dp_valid: got idx %0d expected no issue (t=%0t)", dp_idx, $time);
            end else begin
                issue_t e;
                e = sb.pop_front();
                check("issue_cycle", cyc - t0, e.rel);
                check("dp_idx", 32'(dp_idx), e.idx);
                check("dp_v", 32'(dp_v), 32'(e.v));
                check("dp_u", 32'(dp_u), 32'(e.u));
                check("dp_i", 32'(dp_i), 32'(e.i));
                check("dp_type", 32'(dp_type), 32'(e.t));
            end
        end
    end

    // Start a sweep at the current negedge and follow it to completion.
    // xtick_rel / cur_rel / rst_rel: cycle (relative to tick) at which to
    // inject an extra tick, a current write to neuron 1, or an async reset;
    // -1 disables.
    task automatic do_sweep(input logic [3:0] exp_sv, input int xtick_rel,
                            input int cur_rel, input int rst_rel);
        bit done = 0;
        int rel;
        tick = 1'b1;
        t0   = cyc;
        for (int k = 0; k < N; k++) begin
            sb.push_back('{k, mv[k], mu[k], mi[k], mt[k], 1 + 2 * k});
        end
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            tick   = 1'b0;
            cfg_we = 1'b0;
            cur_we = 1'b0;
            rel    = cyc - t0;
            if (rel == rst_rel) begin
                rst_n = 1'b0;
                #1;
                check("rst_busy", 32'(busy), 0);
                check("rst_dp_valid", 32'(dp_valid), 0);
                check("rst_dp_v", 32'(dp_v), 0);
                check("rst_dp_idx", 32'(dp_idx), 0);
                check("rst_overrun", 32'(overrun), 0);
                check("rst_spike_vec", 32'(spike_vec), 0);
                check("rst_spike_cnt", 32'(spike_cnt), 0);
                sb.delete();
                return;
            end
            if (rel == xtick_rel) tick = 1'b1;
            if (rel == cur_rel) begin
                cur_we  = 1'b1;
                cfg_idx = 2'd1;
                cur_val = 8'h20;
            end
            if (sweep_done) begin
                check("sweep_done_cycle", rel, 9);
                done = 1;
            end
        end
        if (!done) check("sweep_timeout", 0, 1);
        for (int k = 0; k < N; k++) begin
            mv[k] = mv[k] + 18'd1;
            mu[k] = mu[k] + 18'd1;
            if (spike_mask[k] && cm[k] < 255) cm[k]++;
        end
        if (cur_rel >= 0) mi[1] = 8'h20;
        @(negedge clk);
        check("spike_vec", 32'(spike_vec), 32'(exp_sv));
        check("busy_after", 32'(busy), 0);
        check("sb_drained", sb.size(), 0);
    endtask

    initial begin
        bit busy_seen;

        mon_tbl[0] = '{2'd0, 8'hD3};
        mon_tbl[1] = '{2'd1, 8'hD3};
        mon_tbl[2] = '{2'd2, 8'hD3};
        mon_tbl[3] = '{2'd3, 8'hD3};
        sw_tbl[0]  = '{4'b0000, 4'b0000};
        sw_tbl[1]  = '{4'b0100, 4'b0100};
        sw_tbl[2]  = '{4'b0000, 4'b0000};
        sw_tbl[3]  = '{4'b1001, 4'b1001};
        model_reset();

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("reset_busy", 32'(busy), 0);
        check("reset_spike_vec", 32'(spike_vec), 0);
        check("reset_overrun", 32'(overrun), 0);
        check("reset_dp_valid", 32'(dp_valid), 0);
        check("reset_sweep_done", 32'(sweep_done), 0);
        check("reset_dp_v", 32'(dp_v), 0);
        check("reset_spike_cnt", 32'(spike_cnt), 0);
        for (int j = 0; j < 4; j++) begin
            mon_idx = mon_tbl[j].mon;
            #1;
            check("reset_v_mon", 32'(v_mon), 32'(mon_tbl[j].exp_v));
        end
        @(negedge clk);

        // Table of plain sweeps
        ena = 1'b1;
        for (int j = 0; j < 4; j++) begin
            spike_mask = sw_tbl[j].mask;
            do_sweep(sw_tbl[j].exp_sv, -1, -1, -1);
        end

        // Simultaneous cfg+cur write while idle, then a type write to
        // neuron 0 in the tick cycle (visible in this sweep).
        spike_mask = 4'b0000;
        cfg_we = 1'b1; cur_we = 1'b1; cfg_idx = 2'd3; cfg_type = 4'd9; cur_val = 8'hFB;
        mt[3] = 4'd9; mi[3] = 8'hFB;
        @(negedge clk);
        cur_we = 1'b0; cfg_idx = 2'd0; cfg_type = 4'd5;
        mt[0] = 4'd5;
        do_sweep(4'b0000, -1, -1, -1);

        // Current write in the ISSUE cycle of neuron 1: seen next sweep.
        do_sweep(4'b0000, -1, 3, -1);
        do_sweep(4'b0000, -1, -1, -1);

        // Tick during a sweep: dropped, overrun sticky, no second sweep.
        do_sweep(4'b0000, 4, -1, -1);
        check("overrun_set", 32'(overrun), 1);
        busy_seen = 0;
        repeat (12) begin
            @(negedge clk);
            busy_seen |= busy;
        end
        check("no_second_sweep", 32'(busy_seen), 0);
        do_sweep(4'b0000, -1, -1, -1);
        check("overrun_sticky", 32'(overrun), 1);

        // Tick with ena low is ignored and does not set anything.
        ena = 1'b0;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        busy_seen = 0;
        repeat (12) begin
            @(negedge clk);
            busy_seen |= busy | dp_valid;
        end
        check("ena_low_ignored", 32'(busy_seen), 0);
        ena = 1'b1;

        // Neuron 0 spikes every sweep: counter saturates at 255.
        spike_mask = 4'b0001;
        for (int s = 0; s < 300; s++) do_sweep(4'b0001, -1, -1, -1);
        for (int j = 0; j < 4; j++) begin
            mon_idx = 2'(j);
            #1;
            check("spike_cnt", 32'(spike_cnt), 32'(exp_spike_cnt(j)));
        end
        @(negedge clk);

        // Async reset in the WAIT cycle of neuron 1.
        spike_mask = 4'b0000;
        mon_idx = 2'd0;
        do_sweep(4'b0000, -1, -1, 4);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        do_sweep(4'b0000, -1, -1, -1);
        for (int j = 0; j < 4; j++) begin
            mon_idx = mon_tbl[j].mon;
            #1;
            check("post_reset_v_mon", 32'(v_mon), 32'(mon_tbl[j].exp_v));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
